// File: rtl/mm_cdr_v2.sv
// Mueller-Muller clock/data recovery: NRZ/PAM4 slicer, MM phase detector, saturating PI loop
// filter driving a phase-accumulator DCO, and a strobe-qualified lock FSM.
module mm_cdr_v2 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PHASE_BITS = 24,
  parameter int unsigned FCW_NOM    = 1 << (PHASE_BITS - 1),
  parameter int unsigned KP_SHIFT   = 12,
  parameter int unsigned KI_SHIFT   = 18,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned DF_SHIFT   = 8,
  parameter int unsigned LOCK_THR   = 64,
  parameter int unsigned LOCK_N     = 64,
  parameter int unsigned UNLOCK_N   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic                     mode_pam4_i,
  input  logic        [DATA_W-2:0] slice_thr_i,
  input  logic                     freeze_i,
  output logic                     sample_en_o,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] x1_o,
  output logic signed [2:0]        sym_o,
  output logic signed [2:0]        sym1_o,
  output logic signed [DATA_W+3:0] phi_o,
  output logic signed [ACC_W-1:0]  pi_o,
  output logic                     locked_o,
  output logic [1:0]               state_o
);

  localparam int unsigned PW = DATA_W + 4;
  localparam int unsigned SW = ((ACC_W > PW) ? ACC_W : PW) + 2;
  localparam int unsigned EW = ((ACC_W > PHASE_BITS) ? ACC_W : PHASE_BITS) + 2;
  localparam int unsigned GW = $clog2(LOCK_N + 1);
  localparam int unsigned BW = $clog2(UNLOCK_N + 1);

  localparam logic signed [SW-1:0] AccMax = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] AccMin = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [EW-1:0] FcwNom = EW'(FCW_NOM);
  localparam logic signed [EW-1:0] DfMax  = EW'(FCW_NOM >> 10);
  localparam logic signed [EW-1:0] DfMin  = -DfMax;
  localparam logic signed [EW-1:0] EffMin = EW'(1);
  localparam logic signed [EW-1:0] EffMax = EW'((64'd1 << PHASE_BITS) - 64'd1);
  localparam logic [PW:0]          LockThr  = (PW+1)'(LOCK_THR);
  localparam logic [GW-1:0]        GoodLast = GW'(LOCK_N - 1);
  localparam logic [BW-1:0]        BadLast  = BW'(UNLOCK_N - 1);

  typedef enum logic [1:0] {StAcq = 2'd0, StLocked = 2'd1, StHold = 2'd2} state_e;

  logic [PHASE_BITS-1:0]    phase_q;
  logic                     sample_en_q;
  logic signed [DATA_W-1:0] x_q, x1_q;
  logic signed [2:0]        sym, sym1_q;
  logic signed [ACC_W-1:0]  acc_q, pi_q, acc_d, pi_d;
  logic signed [PW-1:0]     phi;
  state_e                   state_q;
  logic [GW-1:0]            good_cnt_q;
  logic [BW-1:0]            bad_cnt_q;
  logic                     locked_q, mode_q;

  // Symbol times sample via shift-add; valid symbols are odd, anything else yields zero.
  function automatic logic signed [PW-1:0] mul_sym(input logic signed [2:0] s,
                                                   input logic signed [DATA_W-1:0] v);
    logic signed [PW-1:0] ve, m;
    ve = {{4{v[DATA_W-1]}}, v};
    m  = (s[2] ^ s[1]) ? (ve <<< 1) + ve : ve;
    if (!s[0]) return '0;
    return s[2] ? -m : m;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > AccMax) return AccMax[ACC_W-1:0];
    if (v < AccMin) return AccMin[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  logic signed [DATA_W:0] x_ext, thr_ext;
  assign x_ext   = {x_q[DATA_W-1], x_q};
  assign thr_ext = {2'b00, slice_thr_i};

  always_comb begin
    sym = 3'sd1;
    if (mode_pam4_i) begin
      if (x_ext < -thr_ext)     sym = -3'sd3;
      else if (x_q[DATA_W-1])   sym = -3'sd1;
      else if (x_ext < thr_ext) sym = 3'sd1;
      else                      sym = 3'sd3;
    end else begin
      sym = x_q[DATA_W-1] ? -3'sd1 : 3'sd1;
    end
  end

  assign phi = mul_sym(sym, x1_q) - mul_sym(sym1_q, x_q);

  logic signed [SW-1:0] phi_s, acc_s, pi_s, acc_sum, pi_sum;
  always_comb begin
    phi_s   = {{(SW-PW){phi[PW-1]}}, phi};
    acc_s   = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    pi_s    = {{(SW-ACC_W){pi_q[ACC_W-1]}}, pi_q};
    acc_sum = acc_s + phi_s;
    pi_sum  = pi_s + (phi_s >>> KP_SHIFT) + (acc_s >>> KI_SHIFT);
    acc_d   = sat(acc_sum);
    pi_d    = sat(pi_sum);
  end

  logic signed [EW-1:0]  pi_e, dfcw_raw, dfcw, eff_c;
  logic [PHASE_BITS-1:0] eff;
  logic [PHASE_BITS:0]   phase_sum;
  always_comb begin
    pi_e     = {{(EW-ACC_W){pi_q[ACC_W-1]}}, pi_q};
    dfcw_raw = pi_e >>> DF_SHIFT;
    if (dfcw_raw > DfMax)      dfcw = DfMax;
    else if (dfcw_raw < DfMin) dfcw = DfMin;
    else                       dfcw = dfcw_raw;
    eff_c = FcwNom + dfcw;
    if (eff_c < EffMin)      eff_c = EffMin;
    else if (eff_c > EffMax) eff_c = EffMax;
    eff       = eff_c[PHASE_BITS-1:0];
    phase_sum = {1'b0, phase_q} + {1'b0, eff};
  end

  logic signed [PW:0] phi_w;
  logic [PW:0]        phi_abs;
  logic               phi_good;
  assign phi_w    = {phi[PW-1], phi};
  assign phi_abs  = phi_w[PW] ? -phi_w : phi_w;
  assign phi_good = (phi_abs <= LockThr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q     <= '0;
      sample_en_q <= 1'b0;
      x_q         <= '0;
      x1_q        <= '0;
      sym1_q      <= '0;
      acc_q       <= '0;
      pi_q        <= '0;
    end else begin
      phase_q     <= phase_sum[PHASE_BITS-1:0];
      sample_en_q <= phase_sum[PHASE_BITS];
      if (sample_en_q) begin
        x_q    <= din_i;
        x1_q   <= x_q;
        sym1_q <= sym;
        if (!freeze_i) begin
          acc_q <= acc_d;
          pi_q  <= pi_d;
        end
      end
    end
  end

  // Lock FSM: a slicing-mode change overrides everything and restarts acquisition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAcq;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      mode_q     <= mode_pam4_i;
    end else begin
      mode_q <= mode_pam4_i;
      if (mode_pam4_i != mode_q) begin
        state_q    <= StAcq;
        good_cnt_q <= '0;
        bad_cnt_q  <= '0;
        locked_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StAcq: begin
            if (sample_en_q && !freeze_i) begin
              if (!phi_good) begin
                good_cnt_q <= '0;
              end else if (good_cnt_q >= GoodLast) begin
                state_q    <= StLocked;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                locked_q   <= 1'b1;
              end else begin
                good_cnt_q <= good_cnt_q + 1'b1;
              end
            end
          end
          StLocked: begin
            if (sample_en_q) begin
              if (freeze_i) begin
                state_q <= StHold;
              end else if (phi_good) begin
                bad_cnt_q <= '0;
              end else if (bad_cnt_q >= BadLast) begin
                state_q    <= StAcq;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                locked_q   <= 1'b0;
              end else begin
                bad_cnt_q <= bad_cnt_q + 1'b1;
              end
            end
          end
          StHold: begin
            if (!freeze_i) begin
              state_q   <= StLocked;
              bad_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= StAcq;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_en_o = sample_en_q;
  assign x_o         = x_q;
  assign x1_o        = x1_q;
  assign sym_o       = sym;
  assign sym1_o      = sym1_q;
  assign phi_o       = phi;
  assign pi_o        = pi_q;
  assign locked_o    = locked_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mm_cdr_v2.sv
// Directed bench for mm_cdr_v2: reset, slicer, phase detector, lock/unlock, freeze/mode and
// loop-filter saturation on a narrow-accumulator instance.
module tb_mm_cdr_v2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] din = '0;
  logic              mode_pam4 = 1'b0;
  logic [6:0]        slice_thr = 7'd64;
  logic              freeze = 1'b0;

  logic              se, locked;
  logic signed [7:0] x, x1;
  logic signed [2:0] sym, sym1;
  logic signed [11:0] phi;
  logic signed [23:0] pi;
  logic [1:0]        state;

  logic              se_s, locked_s;
  logic signed [7:0] x_s, x1_s;
  logic signed [2:0] sym_s, sym1_s;
  logic signed [11:0] phi_s, pi_s;
  logic [1:0]        state_s;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] sl_x   [6] = '{-8'sd100, -8'sd64, -8'sd10, 8'sd0, 8'sd64, 8'sd100};
  logic signed [2:0] sl_pam [6] = '{-3'sd3, -3'sd1, -3'sd1, 3'sd1, 3'sd3, 3'sd3};
  logic signed [2:0] sl_nrz [6] = '{-3'sd1, -3'sd1, -3'sd1, 3'sd1, 3'sd1, 3'sd1};
  // Repeating 10, -100, 120 keeps the NRZ phase error positive on every strobe.
  logic signed [7:0] sat_pat [3] = '{8'sd10, -8'sd100, 8'sd120};

  mm_cdr_v2 dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .mode_pam4_i(mode_pam4),
    .slice_thr_i(slice_thr), .freeze_i(freeze), .sample_en_o(se), .x_o(x), .x1_o(x1),
    .sym_o(sym), .sym1_o(sym1), .phi_o(phi), .pi_o(pi), .locked_o(locked), .state_o(state)
  );

  mm_cdr_v2 #(.ACC_W(12), .KP_SHIFT(0), .KI_SHIFT(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .mode_pam4_i(mode_pam4),
    .slice_thr_i(slice_thr), .freeze_i(freeze), .sample_en_o(se_s), .x_o(x_s), .x1_o(x1_s),
    .sym_o(sym_s), .sym1_o(sym1_s), .phi_o(phi_s), .pi_o(pi_s), .locked_o(locked_s),
    .state_o(state_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present v so that the next strobe captures it; return on the negedge after the capture.
  task automatic strobe(input logic signed [7:0] v);
    int n = 0;
    while (se !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (se !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout sample_en=%b after %0d clk", se, n);
    end
    din = v;
    @(negedge clk);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 64; i++) strobe(8'sd40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = '0; mode_pam4 = 1'b0; slice_thr = 7'd64; freeze = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (se !== 1'b0 || locked !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl se=%b locked=%b state=%0d required 0 0 0", se, locked, state);
    end
    checks++;
    if (x !== 8'sd0 || x1 !== 8'sd0 || sym1 !== 3'sd0 || phi !== 12'sd0) begin
      errors++;
      $display("FAIL reset_data x=%0d x1=%0d sym1=%0d phi=%0d required 0", x, x1, sym1, phi);
    end
    checks++;
    if (pi !== 24'sd0 || pi_s !== 12'sd0) begin
      errors++;
      $display("FAIL reset_pi pi=%0d pi_s=%0d required 0", pi, pi_s);
    end
    rst_n = 1'b1;
    checks++;
    if (sym !== 3'sd1) begin
      errors++;
      $display("FAIL reset_sym sym=%0d required 1", sym);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (se !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL strobe_cadence clk=%0d sample_en=%b required %b", k, se, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_slicer();
    mode_pam4 = 1'b1; slice_thr = 7'd64;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe(sl_x[i]);
      checks++;
      if (x !== sl_x[i] || sym !== sl_pam[i]) begin
        errors++;
        $display("FAIL slicer_pam4 x=%0d sym=%0d required x=%0d sym=%0d", x, sym, sl_x[i],
                 sl_pam[i]);
      end
    end
    mode_pam4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(sl_x[i]);
      checks++;
      if (x !== sl_x[i] || sym !== sl_nrz[i]) begin
        errors++;
        $display("FAIL slicer_nrz x=%0d sym=%0d required x=%0d sym=%0d", x, sym, sl_x[i],
                 sl_nrz[i]);
      end
    end
  endtask

  task automatic test_pd();
    mode_pam4 = 1'b1; slice_thr = 7'd64;
    do_reset();
    strobe(8'sd20);
    strobe(-8'sd80);
    checks++;
    if (x1 !== 8'sd20 || sym1 !== 3'sd1 || sym !== -3'sd3) begin
      errors++;
      $display("FAIL pd_pipe x1=%0d sym1=%0d sym=%0d required 20 1 -3", x1, sym1, sym);
    end
    // -3*20 - (+1)*(-80) = +20
    checks++;
    if (phi !== 12'sd20) begin
      errors++;
      $display("FAIL pd_phi_20 phi=%0d required 20", phi);
    end
    strobe(8'sd40);
    strobe(8'sd40);
    checks++;
    if (phi !== 12'sd0) begin
      errors++;
      $display("FAIL pd_phi_0 phi=%0d required 0", phi);
    end
  endtask

  task automatic test_lock();
    mode_pam4 = 1'b0;
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      strobe(8'sd40);
      if (i == 63) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL lock_early locked=%b required 0 after 63 strobes", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL lock_64 locked=%b state=%0d required 1 1", locked, state);
    end
    // First pattern strobe still evaluates the settled 40/40 pair; bad strobes start at the 2nd.
    for (int j = 1; j <= 17; j++) begin
      strobe((j % 2) ? 8'sd120 : -8'sd10);
      if (j == 16) begin
        checks++;
        if (state !== 2'd1) begin
          errors++;
          $display("FAIL unlock_early state=%0d required 1 after 15 bad", state);
        end
      end
    end
    checks++;
    if (state !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL unlock_16 state=%0d locked=%b required 0 0", state, locked);
    end
  endtask

  task automatic test_freeze_mode();
    logic signed [23:0] held;
    int moved = 0;
    mode_pam4 = 1'b0;
    do_reset();
    lock_up();
    for (int i = 0; i < 20; i++) strobe((i % 2) ? 8'sd40 : 8'sd60);
    checks++;
    if (!(pi < 0) || state !== 2'd1) begin
      errors++;
      $display("FAIL pi_drift pi=%0d state=%0d required pi<0 state 1", pi, state);
    end
    freeze = 1'b1;
    strobe(8'sd60);
    held = pi;
    checks++;
    if (state !== 2'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL hold_enter state=%0d locked=%b required 2 1", state, locked);
    end
    for (int i = 0; i < 50; i++) begin
      strobe((i % 2) ? 8'sd60 : 8'sd40);
      if (pi !== held) moved++;
    end
    checks++;
    if (moved != 0 || state !== 2'd2) begin
      errors++;
      $display("FAIL hold_pi changes=%0d state=%0d required 0 2", moved, state);
    end
    freeze = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL hold_exit state=%0d locked=%b required 1 1", state, locked);
    end
    mode_pam4 = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL mode_toggle state=%0d locked=%b required 0 0", state, locked);
    end
  endtask

  task automatic test_async_reset();
    mode_pam4 = 1'b0;
    do_reset();
    lock_up();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || x !== 8'sd0 || pi !== 24'sd0) begin
      errors++;
      $display("FAIL async_reset state=%0d locked=%b x=%0d pi=%0d required 0", state, locked,
               x, pi);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    int n = 0, cyc = 0, last = 0, gap_bad = 0, wraps = 0;
    bit reached = 1'b0;
    mode_pam4 = 1'b0;
    do_reset();
    for (int c = 0; c < 600 && n < 200; c++) begin
      @(negedge clk);
      cyc++;
      if (reached && pi_s !== 12'sd2047) wraps++;
      if (pi_s === 12'sd2047) reached = 1'b1;
      if (se_s) begin
        if (n >= 100 && (cyc - last) != 2) gap_bad++;
        last = cyc;
        din = sat_pat[n % 3];
        n++;
      end
    end
    checks++;
    if (n != 200) begin
      errors++;
      $display("FAIL sat_strobes count=%0d required 200", n);
    end
    checks++;
    if (!reached || wraps != 0) begin
      errors++;
      $display("FAIL sat_pi pi=%0d reached=%b wraps=%0d required 2047 1 0", pi_s, reached,
               wraps);
    end
    checks++;
    if (dut_s.acc_q !== 12'sd2047) begin
      errors++;
      $display("FAIL sat_acc acc=%0d required 2047", dut_s.acc_q);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL sat_period irregular_gaps=%0d required 0", gap_bad);
    end
  endtask

  initial begin
    test_reset();
    test_slicer();
    test_pd();
    test_lock();
    test_freeze_mode();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
